// File: rtl/graduation_list_mw.sv
// In-order graduation list: multi-lane dispatch, writeback completion tracking,
// in-order multi-lane commit, oldest-exception tracking, partial and full flush.
module graduation_list_mw #(
    parameter  int NUM_ENTRIES = 32,
    parameter  int DISPATCH_W  = 2,
    parameter  int COMMIT_W    = 2,
    parameter  int NUM_WB      = 4,
    parameter  int PAYLOAD_W   = 64,
    localparam int IDX_W       = $clog2(NUM_ENTRIES),
    localparam int CNT_W       = IDX_W + 1
) (
    input  logic                            clk_i,
    input  logic                            rstn_i,
    input  logic [DISPATCH_W-1:0]           disp_valid_i,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload_i,
    input  logic [DISPATCH_W-1:0]           disp_done_i,
    input  logic [DISPATCH_W-1:0]           disp_ex_i,
    output logic                            disp_ready_o,
    output logic [DISPATCH_W*IDX_W-1:0]     disp_idx_o,
    input  logic [NUM_WB-1:0]               wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]         wb_idx_i,
    input  logic [NUM_WB-1:0]               wb_ex_i,
    input  logic                            flush_i,
    input  logic [IDX_W-1:0]                flush_idx_i,
    input  logic                            flush_all_i,
    output logic [COMMIT_W-1:0]             commit_valid_o,
    output logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload_o,
    output logic [COMMIT_W*IDX_W-1:0]       commit_idx_o,
    output logic [COMMIT_W-1:0]             commit_ex_o,
    input  logic [COMMIT_W-1:0]             commit_ack_i,
    output logic                            ex_valid_o,
    output logic [IDX_W-1:0]                ex_idx_o,
    output logic [CNT_W-1:0]                count_o,
    output logic                            empty_o,
    output logic                            full_o
);

    logic [IDX_W-1:0]       r_head;
    logic [IDX_W-1:0]       r_tail;
    logic [CNT_W-1:0]       r_count;
    logic [NUM_ENTRIES-1:0] r_valid;
    logic [NUM_ENTRIES-1:0] r_done;
    logic [NUM_ENTRIES-1:0] r_ex;
    logic [PAYLOAD_W-1:0]   r_payload [NUM_ENTRIES];
    logic                   r_ex_valid;
    logic [IDX_W-1:0]       r_ex_idx;

    logic                   w_flush_eff;
    logic [IDX_W-1:0]       w_flush_age;
    logic                   w_disp_fire;
    logic [CNT_W-1:0]       w_disp_cnt;
    logic [CNT_W-1:0]       w_ack_cnt;
    logic [IDX_W-1:0]       w_disp_idx [DISPATCH_W];
    logic [IDX_W-1:0]       w_cm_idx   [COMMIT_W];
    logic [COMMIT_W-1:0]    w_cm_valid;
    logic [COMMIT_W-1:0]    w_ack;
    logic                   w_open;
    logic [IDX_W-1:0]       w_wb_idx   [NUM_WB];
    logic [IDX_W-1:0]       w_wb_age   [NUM_WB];
    logic [NUM_WB-1:0]      w_wb_ok;
    logic [IDX_W-1:0]       w_ent_age  [NUM_ENTRIES];
    logic [IDX_W-1:0]       w_ex_age;
    logic [NUM_ENTRIES-1:0] w_valid_nxt;
    logic [NUM_ENTRIES-1:0] w_done_nxt;
    logic [NUM_ENTRIES-1:0] w_ex_nxt;
    logic                   w_xbest_v;
    logic [CNT_W-1:0]       w_xbest_age;
    logic [IDX_W-1:0]       w_xbest_idx;
    logic [IDX_W-1:0]       w_head_nxt;
    logic [IDX_W-1:0]       w_tail_nxt;
    logic [CNT_W-1:0]       w_count_nxt;

    function automatic logic [IDX_W-1:0] f_age(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] head);
        return idx - head;
    endfunction

    assign w_flush_eff  = flush_i && !flush_all_i && (r_count != '0);
    assign w_flush_age  = f_age(flush_idx_i, r_head);
    assign w_ex_age     = f_age(r_ex_idx, r_head);
    // Readiness uses the registered count, so freed slots are never reused in the same cycle.
    assign disp_ready_o = ((CNT_W'(NUM_ENTRIES) - r_count) >= CNT_W'(DISPATCH_W))
                          && !flush_i && !flush_all_i;
    assign w_disp_fire  = disp_ready_o;

    for (genvar gi = 0; gi < DISPATCH_W; gi++) begin : g_disp
        assign w_disp_idx[gi]                    = r_tail + IDX_W'(gi);
        assign disp_idx_o[gi*IDX_W +: IDX_W]     = w_disp_idx[gi];
    end

    for (genvar gc = 0; gc < COMMIT_W; gc++) begin : g_cm
        assign w_cm_idx[gc]                            = r_head + IDX_W'(gc);
        assign commit_idx_o[gc*IDX_W +: IDX_W]         = w_cm_idx[gc];
        assign commit_payload_o[gc*PAYLOAD_W +: PAYLOAD_W] = r_payload[w_cm_idx[gc]];
        assign commit_ex_o[gc]                         = w_cm_valid[gc] & r_ex[w_cm_idx[gc]];
    end

    for (genvar gp = 0; gp < NUM_WB; gp++) begin : g_wb
        assign w_wb_idx[gp] = wb_idx_i[gp*IDX_W +: IDX_W];
        assign w_wb_age[gp] = f_age(w_wb_idx[gp], r_head);
        assign w_wb_ok[gp]  = wb_valid_i[gp] && !flush_all_i
                              && ({1'b0, w_wb_age[gp]} < r_count)
                              && !(w_flush_eff && (w_wb_age[gp] > w_flush_age));
    end

    for (genvar ge = 0; ge < NUM_ENTRIES; ge++) begin : g_age
        assign w_ent_age[ge] = f_age(IDX_W'(ge), r_head);
    end

    // A lane closes the window behind it if it is not retirable or carries an exception.
    always_comb begin
        w_cm_valid = '0;
        w_open     = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (w_open && (CNT_W'(i) < r_count) && r_valid[w_cm_idx[i]] && r_done[w_cm_idx[i]]) begin
                w_cm_valid[i] = 1'b1;
                w_open        = !r_ex[w_cm_idx[i]];
            end else begin
                w_open = 1'b0;
            end
        end
    end

    assign commit_valid_o = w_cm_valid;
    assign w_ack          = commit_ack_i & w_cm_valid & {COMMIT_W{!flush_all_i}};

    always_comb begin
        w_disp_cnt = '0;
        w_ack_cnt  = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (w_disp_fire && disp_valid_i[i]) w_disp_cnt = w_disp_cnt + CNT_W'(1);
        end
        for (int i = 0; i < COMMIT_W; i++) begin
            if (w_ack[i]) w_ack_cnt = w_ack_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_valid_nxt = r_valid;
        w_done_nxt  = r_done;
        w_ex_nxt    = r_ex;
        if (flush_all_i) begin
            w_valid_nxt = '0;
            w_done_nxt  = '0;
            w_ex_nxt    = '0;
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (w_wb_ok[p]) begin
                    w_done_nxt[w_wb_idx[p]] = 1'b1;
                    if (wb_ex_i[p]) w_ex_nxt[w_wb_idx[p]] = 1'b1;
                end
            end
            if (w_flush_eff) begin
                for (int e = 0; e < NUM_ENTRIES; e++) begin
                    if (w_ent_age[e] > w_flush_age) begin
                        w_valid_nxt[e] = 1'b0;
                        w_done_nxt[e]  = 1'b0;
                        w_ex_nxt[e]    = 1'b0;
                    end
                end
            end
            if (w_disp_fire) begin
                for (int i = 0; i < DISPATCH_W; i++) begin
                    if (disp_valid_i[i]) begin
                        w_valid_nxt[w_disp_idx[i]] = 1'b1;
                        w_done_nxt[w_disp_idx[i]]  = disp_done_i[i] | disp_ex_i[i];
                        w_ex_nxt[w_disp_idx[i]]    = disp_ex_i[i];
                    end
                end
            end
            for (int i = 0; i < COMMIT_W; i++) begin
                if (w_ack[i]) begin
                    w_valid_nxt[w_cm_idx[i]] = 1'b0;
                    w_done_nxt[w_cm_idx[i]]  = 1'b0;
                    w_ex_nxt[w_cm_idx[i]]    = 1'b0;
                end
            end
        end
    end

    // Oldest exception: candidates retiring this cycle or being squashed are excluded up front.
    always_comb begin
        w_xbest_v   = 1'b0;
        w_xbest_age = '0;
        w_xbest_idx = '0;
        if (r_ex_valid && ({1'b0, w_ex_age} >= w_ack_cnt)
            && !(w_flush_eff && (w_ex_age > w_flush_age))) begin
            w_xbest_v   = 1'b1;
            w_xbest_age = {1'b0, w_ex_age};
            w_xbest_idx = r_ex_idx;
        end
        for (int p = 0; p < NUM_WB; p++) begin
            if (w_wb_ok[p] && wb_ex_i[p] && ({1'b0, w_wb_age[p]} >= w_ack_cnt)
                && (!w_xbest_v || ({1'b0, w_wb_age[p]} < w_xbest_age))) begin
                w_xbest_v   = 1'b1;
                w_xbest_age = {1'b0, w_wb_age[p]};
                w_xbest_idx = w_wb_idx[p];
            end
        end
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (w_disp_fire && disp_valid_i[i] && disp_ex_i[i]
                && (!w_xbest_v || ((r_count + CNT_W'(i)) < w_xbest_age))) begin
                w_xbest_v   = 1'b1;
                w_xbest_age = r_count + CNT_W'(i);
                w_xbest_idx = w_disp_idx[i];
            end
        end
        if (flush_all_i) begin
            w_xbest_v   = 1'b0;
            w_xbest_idx = '0;
        end
    end

    always_comb begin
        if (flush_all_i) begin
            w_head_nxt  = '0;
            w_tail_nxt  = '0;
            w_count_nxt = '0;
        end else if (w_flush_eff) begin
            w_head_nxt  = r_head + w_ack_cnt[IDX_W-1:0];
            w_tail_nxt  = flush_idx_i + IDX_W'(1);
            w_count_nxt = {1'b0, w_flush_age} + CNT_W'(1) - w_ack_cnt;
        end else begin
            w_head_nxt  = r_head + w_ack_cnt[IDX_W-1:0];
            w_tail_nxt  = r_tail + w_disp_cnt[IDX_W-1:0];
            w_count_nxt = r_count + w_disp_cnt - w_ack_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_done     <= '0;
            r_ex       <= '0;
            r_ex_valid <= 1'b0;
            r_ex_idx   <= '0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
            r_ex       <= w_ex_nxt;
            r_ex_valid <= w_xbest_v;
            r_ex_idx   <= w_xbest_idx;
        end
    end

    // Payload storage is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DISPATCH_W; i++) begin
            if (w_disp_fire && disp_valid_i[i])
                r_payload[w_disp_idx[i]] <= disp_payload_i[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end

    assign ex_valid_o = r_ex_valid;
    assign ex_idx_o   = r_ex_idx;
    assign count_o    = r_count;
    assign empty_o    = (r_count == '0);
    assign full_o     = (r_count == CNT_W'(NUM_ENTRIES));

endmodule

// File: tb/tb_graduation_list_mw.sv
// Scenario bench for graduation_list_mw: a scoreboard queue holds expected commits in program order.
module tb_graduation_list_mw;

    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [1:0]   disp_valid_i, disp_done_i, disp_ex_i;
    logic [127:0] disp_payload_i;
    logic         disp_ready_o;
    logic [9:0]   disp_idx_o;
    logic [3:0]   wb_valid_i, wb_ex_i;
    logic [19:0]  wb_idx_i;
    logic         flush_i, flush_all_i;
    logic [4:0]   flush_idx_i;
    logic [1:0]   commit_valid_o, commit_ex_o, commit_ack_i;
    logic [127:0] commit_payload_o;
    logic [9:0]   commit_idx_o;
    logic         ex_valid_o;
    logic [4:0]   ex_idx_o;
    logic [5:0]   count_o;
    logic         empty_o, full_o;

    typedef struct packed {
        logic [4:0]  idx;
        logic [63:0] pl;
        logic        ex;
    } exp_t;

    exp_t       sb[$];
    logic [4:0] m_head, m_tail;
    int         n_checks = 0;
    int         n_pass   = 0;

    graduation_list_mw dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .disp_valid_i(disp_valid_i), .disp_payload_i(disp_payload_i),
        .disp_done_i(disp_done_i), .disp_ex_i(disp_ex_i),
        .disp_ready_o(disp_ready_o), .disp_idx_o(disp_idx_o),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i), .wb_ex_i(wb_ex_i),
        .flush_i(flush_i), .flush_idx_i(flush_idx_i), .flush_all_i(flush_all_i),
        .commit_valid_o(commit_valid_o), .commit_payload_o(commit_payload_o),
        .commit_idx_o(commit_idx_o), .commit_ex_o(commit_ex_o), .commit_ack_i(commit_ack_i),
        .ex_valid_o(ex_valid_o), .ex_idx_o(ex_idx_o), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [70:0] lane_got(input int i);
        return {commit_valid_o[i], commit_idx_o[i*5 +: 5], commit_payload_o[i*64 +: 64], commit_ex_o[i]};
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        disp_valid_i = '0; disp_done_i = '0; disp_ex_i = '0; disp_payload_i = '0;
        wb_valid_i = '0; wb_idx_i = '0; wb_ex_i = '0;
        flush_i = 1'b0; flush_idx_i = '0; flush_all_i = 1'b0; commit_ack_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn_i = 1'b0;
        cyc();
        cyc();
        rstn_i = 1'b1;
        sb.delete();
        m_head = '0;
        m_tail = '0;
    endtask

    task automatic set_disp(input int n, input logic [1:0] dn, input logic [1:0] ex);
        exp_t e;
        logic [63:0] pl;
        disp_valid_i = '0;
        for (int i = 0; i < n; i++) begin
            pl = {$urandom(), $urandom()};
            disp_payload_i[i*64 +: 64] = pl;
            disp_valid_i[i] = 1'b1;
            disp_done_i[i]  = dn[i];
            disp_ex_i[i]    = ex[i];
            e.idx = m_tail + 5'(i);
            e.pl  = pl;
            e.ex  = ex[i];
            sb.push_back(e);
        end
        m_tail = m_tail + 5'(n);
    endtask

    task automatic drive_disp(input int n, input logic [1:0] dn, input logic [1:0] ex);
        set_disp(n, dn, ex);
        cyc();
        disp_valid_i = '0; disp_done_i = '0; disp_ex_i = '0;
    endtask

    task automatic set_wb(input int p, input logic [4:0] idx, input logic ex);
        wb_valid_i[p] = 1'b1;
        wb_idx_i[p*5 +: 5] = idx;
        wb_ex_i[p] = ex;
        if (ex) begin
            for (int k = 0; k < sb.size(); k++)
                if (sb[k].idx == idx) sb[k].ex = 1'b1;
        end
    endtask

    task automatic ack(input int n);
        commit_ack_i = (n == 2) ? 2'b11 : 2'b01;
        cyc();
        commit_ack_i = '0;
        repeat (n) void'(sb.pop_front());
        m_head = m_head + 5'(n);
    endtask

    task automatic test_reset();
        do_reset();
        rstn_i = 1'b0;
        #1;
        n_checks++; if (count_o !== 6'd0) $display("FAIL reset_count got=%0d exp=0", count_o); else n_pass++;
        n_checks++; if ({empty_o, full_o} !== 2'b10) $display("FAIL reset_empty_full got=%b exp=10", {empty_o, full_o}); else n_pass++;
        n_checks++; if (disp_ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", disp_ready_o); else n_pass++;
        n_checks++; if (commit_valid_o !== 2'b00) $display("FAIL reset_commit_valid got=%b exp=00", commit_valid_o); else n_pass++;
        n_checks++; if ({ex_valid_o, ex_idx_o} !== 6'd0) $display("FAIL reset_ex got=%b/%0d exp=0/0", ex_valid_o, ex_idx_o); else n_pass++;
        flush_i = 1'b1;
        #1;
        n_checks++; if (disp_ready_o !== 1'b0) $display("FAIL reset_ready_flush got=%b exp=0", disp_ready_o); else n_pass++;
        flush_i = 1'b0;
        rstn_i = 1'b1;
        cyc();
    endtask

    task automatic test_full();
        do_reset();
        repeat (31) drive_disp(1, 2'b00, 2'b00);
        n_checks++; if (count_o !== 6'd31) $display("FAIL full31_count got=%0d exp=31", count_o); else n_pass++;
        n_checks++; if ({disp_ready_o, full_o} !== 2'b00) $display("FAIL full31_ready_full got=%b exp=00", {disp_ready_o, full_o}); else n_pass++;
        rstn_i = 1'b0;
        #1;
        n_checks++; if ({count_o, empty_o} !== 7'b0000001) $display("FAIL midreset got=%0d/%b exp=0/1", count_o, empty_o); else n_pass++;
        do_reset();
        repeat (30) drive_disp(1, 2'b00, 2'b00);
        n_checks++; if (disp_ready_o !== 1'b1) $display("FAIL full30_ready got=%b exp=1", disp_ready_o); else n_pass++;
        drive_disp(2, 2'b00, 2'b00);
        n_checks++; if (count_o !== 6'd32) $display("FAIL full_count got=%0d exp=32", count_o); else n_pass++;
        n_checks++; if ({full_o, disp_ready_o, empty_o} !== 3'b100) $display("FAIL full_flags got=%b exp=100", {full_o, disp_ready_o, empty_o}); else n_pass++;
        n_checks++; if ({disp_idx_o[4:0], commit_idx_o[4:0]} !== {m_tail, m_head}) $display("FAIL full_ptrs got=%0d/%0d exp=%0d/%0d", disp_idx_o[4:0], commit_idx_o[4:0], m_tail, m_head); else n_pass++;
        n_checks++; if (commit_valid_o !== 2'b00) $display("FAIL full_commit got=%b exp=00", commit_valid_o); else n_pass++;
    endtask

    task automatic test_commit_order();
        do_reset();
        drive_disp(2, 2'b00, 2'b00);
        drive_disp(2, 2'b00, 2'b00);
        n_checks++; if (commit_valid_o !== 2'b00) $display("FAIL co_none got=%b exp=00", commit_valid_o); else n_pass++;
        set_wb(0, 5'd3, 1'b0); set_wb(1, 5'd1, 1'b0); set_wb(2, 5'd0, 1'b0);
        cyc();
        wb_valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL co_lane%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
        n_checks++; if ({commit_valid_o, commit_idx_o[4:0]} !== {2'b00, 5'd2}) $display("FAIL co_wait2 got=%b/%0d exp=00/2", commit_valid_o, commit_idx_o[4:0]); else n_pass++;
        set_wb(3, 5'd2, 1'b0);
        cyc();
        wb_valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL co_lane2_%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
        n_checks++; if ({empty_o, count_o} !== 7'b1000000) $display("FAIL co_empty got=%b/%0d exp=1/0", empty_o, count_o); else n_pass++;
        set_wb(0, 5'd5, 1'b0);
        cyc();
        wb_valid_i = '0;
        drive_disp(2, 2'b00, 2'b00);
        n_checks++; if (commit_valid_o !== 2'b00) $display("FAIL co_dead_wb got=%b exp=00", commit_valid_o); else n_pass++;
        set_wb(0, 5'd4, 1'b0); set_wb(1, 5'd5, 1'b0); set_wb(2, 5'd5, 1'b0);
        cyc();
        wb_valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL co_lane3_%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
    endtask

    task automatic test_exception();
        do_reset();
        repeat (3) drive_disp(2, 2'b00, 2'b00);
        set_wb(0, 5'd4, 1'b1);
        cyc();
        wb_valid_i = '0; wb_ex_i = '0;
        n_checks++; if ({ex_valid_o, ex_idx_o} !== {1'b1, 5'd4}) $display("FAIL ex_first got=%b/%0d exp=1/4", ex_valid_o, ex_idx_o); else n_pass++;
        set_wb(1, 5'd2, 1'b1);
        cyc();
        wb_valid_i = '0; wb_ex_i = '0;
        n_checks++; if ({ex_valid_o, ex_idx_o} !== {1'b1, 5'd2}) $display("FAIL ex_older got=%b/%0d exp=1/2", ex_valid_o, ex_idx_o); else n_pass++;
        set_wb(0, 5'd0, 1'b0); set_wb(1, 5'd1, 1'b0); set_wb(2, 5'd3, 1'b0); set_wb(3, 5'd5, 1'b0);
        cyc();
        wb_valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL ex_lane%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
        n_checks++; if ({commit_valid_o, commit_ex_o} !== 4'b0101) $display("FAIL ex_stop got=%b/%b exp=01/01", commit_valid_o, commit_ex_o); else n_pass++;
        n_checks++; if (lane_got(0) !== {1'b1, sb[0]}) $display("FAIL ex_head_lane got=%h exp=%h", lane_got(0), {1'b1, sb[0]}); else n_pass++;
        ack(1);
        n_checks++; if (ex_valid_o !== 1'b0) $display("FAIL ex_cleared got=%b exp=0", ex_valid_o); else n_pass++;
        n_checks++; if ({commit_valid_o, commit_ex_o} !== 4'b1110) $display("FAIL ex_last got=%b/%b exp=11/10", commit_valid_o, commit_ex_o); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL ex_lane2_%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
        ack(1);
        n_checks++; if (empty_o !== 1'b1) $display("FAIL ex_empty got=%b exp=1", empty_o); else n_pass++;
    endtask

    task automatic test_flush_wrap();
        do_reset();
        repeat (15) drive_disp(2, 2'b11, 2'b00);
        repeat (15) ack(2);
        repeat (3) drive_disp(2, 2'b00, 2'b00);
        n_checks++; if ({count_o, commit_idx_o[4:0], disp_idx_o[4:0]} !== {6'd6, 5'd30, 5'd4}) $display("FAIL fw_setup got=%0d/%0d/%0d exp=6/30/4", count_o, commit_idx_o[4:0], disp_idx_o[4:0]); else n_pass++;
        set_wb(0, 5'd1, 1'b1);
        cyc();
        wb_valid_i = '0; wb_ex_i = '0;
        n_checks++; if ({ex_valid_o, ex_idx_o} !== {1'b1, 5'd1}) $display("FAIL fw_ex got=%b/%0d exp=1/1", ex_valid_o, ex_idx_o); else n_pass++;
        flush_i = 1'b1; flush_idx_i = 5'd31; disp_valid_i = 2'b01;
        #1;
        n_checks++; if (disp_ready_o !== 1'b0) $display("FAIL fw_ready got=%b exp=0", disp_ready_o); else n_pass++;
        cyc();
        clear_inputs();
        while (sb.size() > 2) void'(sb.pop_back());
        m_tail = 5'd0;
        n_checks++; if ({count_o, disp_idx_o[4:0]} !== {6'd2, m_tail}) $display("FAIL fw_ptrs got=%0d/%0d exp=2/%0d", count_o, disp_idx_o[4:0], m_tail); else n_pass++;
        n_checks++; if (ex_valid_o !== 1'b0) $display("FAIL fw_ex_squashed got=%b exp=0", ex_valid_o); else n_pass++;
        set_wb(0, 5'd30, 1'b0); set_wb(1, 5'd31, 1'b0);
        cyc();
        wb_valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL fw_lane%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
        flush_i = 1'b1; flush_idx_i = 5'd7;
        cyc();
        clear_inputs();
        n_checks++; if ({count_o, disp_idx_o[4:0], commit_idx_o[4:0]} !== {6'd0, m_tail, m_head}) $display("FAIL fw_noop got=%0d/%0d/%0d exp=0/%0d/%0d", count_o, disp_idx_o[4:0], commit_idx_o[4:0], m_tail, m_head); else n_pass++;
    endtask

    task automatic test_flush_ack();
        do_reset();
        drive_disp(2, 2'b11, 2'b00);
        drive_disp(2, 2'b00, 2'b00);
        drive_disp(2, 2'b00, 2'b00);
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL fa_lane%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        commit_ack_i = 2'b11; flush_i = 1'b1; flush_idx_i = m_head + 5'd4; disp_valid_i = 2'b11;
        #1;
        n_checks++; if (disp_ready_o !== 1'b0) $display("FAIL fa_ready got=%b exp=0", disp_ready_o); else n_pass++;
        cyc();
        clear_inputs();
        void'(sb.pop_front()); void'(sb.pop_front()); void'(sb.pop_back());
        m_head = 5'd2; m_tail = 5'd5;
        n_checks++; if (count_o !== 6'd3) $display("FAIL fa_count got=%0d exp=3", count_o); else n_pass++;
        n_checks++; if ({disp_idx_o[4:0], commit_idx_o[4:0], commit_valid_o} !== {m_tail, m_head, 2'b00}) $display("FAIL fa_ptrs got=%0d/%0d/%b exp=%0d/%0d/00", disp_idx_o[4:0], commit_idx_o[4:0], commit_valid_o, m_tail, m_head); else n_pass++;
        set_wb(0, 5'd2, 1'b0); set_wb(1, 5'd3, 1'b0); set_wb(2, 5'd4, 1'b0);
        cyc();
        wb_valid_i = '0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL fa_lane2_%0d got=%h exp=%h", i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
        end
        ack(2);
        n_checks++; if ({commit_valid_o, count_o} !== {2'b01, 6'd1}) $display("FAIL fa_tail got=%b/%0d exp=01/1", commit_valid_o, count_o); else n_pass++;
        ack(1);
    endtask

    task automatic test_flush_all();
        do_reset();
        drive_disp(2, 2'b00, 2'b00);
        drive_disp(2, 2'b00, 2'b10);
        n_checks++; if ({ex_valid_o, ex_idx_o} !== {1'b1, 5'd3}) $display("FAIL fl_disp_ex got=%b/%0d exp=1/3", ex_valid_o, ex_idx_o); else n_pass++;
        set_wb(0, 5'd0, 1'b0);
        cyc();
        wb_valid_i = '0;
        n_checks++; if (commit_valid_o !== 2'b01) $display("FAIL fl_pre got=%b exp=01", commit_valid_o); else n_pass++;
        commit_ack_i = 2'b01; set_wb(1, 5'd1, 1'b1); disp_valid_i = 2'b11; disp_done_i = 2'b11;
        flush_all_i = 1'b1;
        #1;
        n_checks++; if (disp_ready_o !== 1'b0) $display("FAIL fl_ready got=%b exp=0", disp_ready_o); else n_pass++;
        cyc();
        clear_inputs();
        sb.delete();
        m_head = '0; m_tail = '0;
        n_checks++; if ({count_o, empty_o, ex_valid_o} !== {6'd0, 1'b1, 1'b0}) $display("FAIL fl_state got=%0d/%b/%b exp=0/1/0", count_o, empty_o, ex_valid_o); else n_pass++;
        n_checks++; if ({disp_idx_o[4:0], commit_idx_o[4:0], commit_valid_o} !== {m_tail, m_head, 2'b00}) $display("FAIL fl_ptrs got=%0d/%0d/%b exp=0/0/00", disp_idx_o[4:0], commit_idx_o[4:0], commit_valid_o); else n_pass++;
        drive_disp(1, 2'b01, 2'b00);
        n_checks++; if ({commit_valid_o[1], lane_got(0)} !== {1'b0, 1'b1, sb[0]}) $display("FAIL fl_after got=%b/%h exp=0/%h", commit_valid_o[1], lane_got(0), {1'b1, sb[0]}); else n_pass++;
        ack(1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_disp(2, 2'b11, 2'b00);
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 2; i++) begin
                n_checks++; if (lane_got(i) !== {1'b1, sb[i]}) $display("FAIL b2b_%0d_lane%0d got=%h exp=%h", k, i, lane_got(i), {1'b1, sb[i]}); else n_pass++;
            end
            commit_ack_i = 2'b11;
            set_disp(2, 2'b11, 2'b00);
            cyc();
            clear_inputs();
            void'(sb.pop_front()); void'(sb.pop_front());
            m_head = m_head + 5'd2;
        end
        n_checks++; if ({count_o, commit_idx_o[4:0]} !== {6'd2, m_head}) $display("FAIL b2b_state got=%0d/%0d exp=2/%0d", count_o, commit_idx_o[4:0], m_head); else n_pass++;
        ack(2);
        n_checks++; if (empty_o !== 1'b1) $display("FAIL b2b_empty got=%b exp=1", empty_o); else n_pass++;
    endtask

    initial begin
        clear_inputs();
        rstn_i = 1'b0;
        test_reset();
        test_full();
        test_commit_order();
        test_exception();
        test_flush_wrap();
        test_flush_ack();
        test_flush_all();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
